// File: rtl/dft_frame_sequencer.sv
`default_nettype none
// dft_frame_sequencer: buffers one PTS-point frame, bursts it gap-free into the DFT core,
// and frames/validates the core's result stream.  Rev 1.0
module dft_frame_sequencer #(
  parameter int N         = 18,
  parameter int SIZE_CODE = 4,
  parameter int PTS       = 60
) (
  input  logic         CLK,
  input  logic         SCLR,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_re,
  input  logic [N-1:0] s_im,
  input  logic         fwd_inv,
  output logic         dft_sclr,
  output logic [N-1:0] dft_xn_re,
  output logic [N-1:0] dft_xn_im,
  output logic         dft_fd_in,
  output logic         dft_fwd_inv,
  output logic [5:0]   dft_size,
  input  logic         dft_rffd,
  input  logic [N-1:0] dft_xk_re,
  input  logic [N-1:0] dft_xk_im,
  input  logic [3:0]   dft_blk_exp,
  input  logic         dft_fd_out,
  input  logic         dft_data_valid,
  output logic         m_valid,
  output logic [N-1:0] m_re,
  output logic [N-1:0] m_im,
  output logic         m_first,
  output logic         m_last,
  output logic [3:0]   m_blk_exp,
  output logic [15:0]  frames_done,
  output logic         err
);

  localparam int CW = $clog2(PTS + 1);
  localparam int AW = (PTS > 1) ? $clog2(PTS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PTS - 1);
  localparam logic [CW-1:0] PTS_CNT  = CW'(PTS);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ARM   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
  logic           frame_dir_q, frame_dir_d;
  logic [N-1:0]   xn_re_q, xn_re_d;
  logic [N-1:0]   xn_im_q, xn_im_d;
  logic           fd_in_q, fd_in_d;
  logic           fwd_inv_q, fwd_inv_d;
  logic           accept;
  logic [AW-1:0]  rd_addr;
  logic [2*N-1:0] mem [PTS];
  logic [2*N-1:0] rd_data_q;

  logic           m_valid_q, m_valid_d;
  logic [N-1:0]   m_re_q, m_re_d;
  logic [N-1:0]   m_im_q, m_im_d;
  logic           m_first_q, m_first_d;
  logic           m_last_q, m_last_d;
  logic [3:0]     m_blk_exp_q, m_blk_exp_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic [15:0]    frames_done_q, frames_done_d;
  logic           err_q, err_d;

  // rd_cnt runs one ahead of the burst beat because the RAM read is registered.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_dir_d = frame_dir_q;
    s_ready     = 1'b0;
    accept      = 1'b0;
    case (state_q)
      S_FILL: begin
        s_ready = ~SCLR;
        accept  = s_valid & ~SCLR;
        if (accept) begin
          if (wr_cnt_q == '0) frame_dir_d = fwd_inv;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            state_d  = S_ARM;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_ARM: begin
        rd_cnt_d = '0;
        if (dft_rffd) begin
          state_d  = S_BURST;
          rd_cnt_d = ONE_CNT;
        end
      end
      S_BURST: begin
        if (rd_cnt_q == PTS_CNT) begin
          state_d  = S_FILL;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    rd_addr   = (rd_cnt_q < PTS_CNT) ? rd_cnt_q[AW-1:0] : '0;
    xn_re_d   = '0;
    xn_im_d   = '0;
    fd_in_d   = 1'b0;
    fwd_inv_d = 1'b0;
    if (state_q == S_BURST) begin
      xn_re_d   = rd_data_q[2*N-1:N];
      xn_im_d   = rd_data_q[N-1:0];
      fd_in_d   = (rd_cnt_q == ONE_CNT);
      fwd_inv_d = frame_dir_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) mem[wr_cnt_q[AW-1:0]] <= {s_re, s_im};
    rd_data_q <= mem[rd_addr];
  end

  // out_cnt == 0 means "between frames"; the last beat returns it there.
  always_comb begin
    m_valid_d     = dft_data_valid;
    m_re_d        = dft_xk_re;
    m_im_d        = dft_xk_im;
    m_first_d     = 1'b0;
    m_last_d      = 1'b0;
    m_blk_exp_d   = m_blk_exp_q;
    out_cnt_d     = out_cnt_q;
    frames_done_d = frames_done_q;
    err_d         = err_q;
    if (dft_data_valid) begin
      if (dft_fd_out) begin
        m_first_d   = 1'b1;
        m_blk_exp_d = dft_blk_exp;
        out_cnt_d   = ONE_CNT;
        if (out_cnt_q != '0) err_d = 1'b1;
      end else if (out_cnt_q == '0) begin
        err_d = 1'b1;
      end else if (out_cnt_q == LAST_IDX) begin
        m_last_d      = 1'b1;
        out_cnt_d     = '0;
        frames_done_d = frames_done_q + 16'd1;
      end else begin
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (SCLR) begin
      state_q       <= S_FILL;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      frame_dir_q   <= 1'b0;
      xn_re_q       <= '0;
      xn_im_q       <= '0;
      fd_in_q       <= 1'b0;
      fwd_inv_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_re_q        <= '0;
      m_im_q        <= '0;
      m_first_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_blk_exp_q   <= '0;
      out_cnt_q     <= '0;
      frames_done_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      frame_dir_q   <= frame_dir_d;
      xn_re_q       <= xn_re_d;
      xn_im_q       <= xn_im_d;
      fd_in_q       <= fd_in_d;
      fwd_inv_q     <= fwd_inv_d;
      m_valid_q     <= m_valid_d;
      m_re_q        <= m_re_d;
      m_im_q        <= m_im_d;
      m_first_q     <= m_first_d;
      m_last_q      <= m_last_d;
      m_blk_exp_q   <= m_blk_exp_d;
      out_cnt_q     <= out_cnt_d;
      frames_done_q <= frames_done_d;
      err_q         <= err_d;
    end
  end

  assign dft_sclr    = SCLR;
  assign dft_size    = 6'(SIZE_CODE);
  assign dft_xn_re   = xn_re_q;
  assign dft_xn_im   = xn_im_q;
  assign dft_fd_in   = fd_in_q;
  assign dft_fwd_inv = fwd_inv_q;
  assign m_valid     = m_valid_q;
  assign m_re        = m_re_q;
  assign m_im        = m_im_q;
  assign m_first     = m_first_q;
  assign m_last      = m_last_q;
  assign m_blk_exp   = m_blk_exp_q;
  assign frames_done = frames_done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dft_frame_sequencer.sv
`default_nettype none
// tb_dft_frame_sequencer: scoreboard bench for dft_frame_sequencer (core-input bursts and result framing).
module tb_dft_frame_sequencer;
  localparam int N   = 18;
  localparam int PTS = 60;

  logic         CLK = 1'b0;
  logic         SCLR = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [N-1:0] s_re = '0, s_im = '0;
  logic         fwd_inv = 1'b0;
  logic         dft_sclr;
  logic [N-1:0] dft_xn_re, dft_xn_im;
  logic         dft_fd_in, dft_fwd_inv;
  logic [5:0]   dft_size;
  logic         dft_rffd = 1'b0;
  logic [N-1:0] dft_xk_re = '0, dft_xk_im = '0;
  logic [3:0]   dft_blk_exp = '0;
  logic         dft_fd_out = 1'b0, dft_data_valid = 1'b0;
  logic         m_valid;
  logic [N-1:0] m_re, m_im;
  logic         m_first, m_last;
  logic [3:0]   m_blk_exp;
  logic [15:0]  frames_done;
  logic         err;

  always #5 CLK = ~CLK;

  dft_frame_sequencer #(.N(N), .SIZE_CODE(4), .PTS(PTS)) dut (
    .CLK(CLK), .SCLR(SCLR), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .fwd_inv(fwd_inv), .dft_sclr(dft_sclr), .dft_xn_re(dft_xn_re), .dft_xn_im(dft_xn_im),
    .dft_fd_in(dft_fd_in), .dft_fwd_inv(dft_fwd_inv), .dft_size(dft_size), .dft_rffd(dft_rffd),
    .dft_xk_re(dft_xk_re), .dft_xk_im(dft_xk_im), .dft_blk_exp(dft_blk_exp), .dft_fd_out(dft_fd_out),
    .dft_data_valid(dft_data_valid), .m_valid(m_valid), .m_re(m_re), .m_im(m_im),
    .m_first(m_first), .m_last(m_last), .m_blk_exp(m_blk_exp), .frames_done(frames_done), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames of accepted samples become expected bursts; core beats become expected results.
  typedef struct packed {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         fd;
    logic         dir;
  } bexp_t;

  typedef struct packed {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         is_first;
    logic         is_last;
    logic [3:0]   bexp;
    logic [15:0]  fdone;
    logic         err;
  } mexp_t;

  bexp_t          burst_q[$];
  logic [2*N-1:0] frm[$];
  logic           frm_dir = 1'b0;
  int             bcnt = 0;
  mexp_t          m_q[$];
  int             m_idx = -1;
  logic [15:0]    m_frames = '0;
  logic [3:0]     m_bexp = '0;
  logic           m_err = 1'b0;
  bit             rand_rffd = 1'b0;

  function automatic void model_flush();
    frm.delete();
    m_idx    = -1;
    m_frames = '0;
    m_bexp   = '0;
    m_err    = 1'b0;
  endfunction

  function automatic void model_accept(input logic [N-1:0] re, input logic [N-1:0] im, input logic dir);
    bexp_t e;
    if (frm.size() == 0) frm_dir = dir;
    frm.push_back({re, im});
    if (frm.size() == PTS) begin
      for (int i = 0; i < PTS; i++) begin
        e.re  = frm[i][2*N-1:N];
        e.im  = frm[i][N-1:0];
        e.fd  = (i == 0);
        e.dir = frm_dir;
        burst_q.push_back(e);
      end
      frm.delete();
    end
  endfunction

  // Called at a falling edge; returns at a falling edge after the sample is accepted.
  task automatic push_sample(input logic [N-1:0] re, input logic [N-1:0] im, input logic dir, output int waits);
    bit acc;
    waits   = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    fwd_inv = dir;
    while (!acc) begin
      if (rand_rffd) dft_rffd = ($urandom_range(0, 3) != 0);
      #1 acc = s_ready;
      @(posedge CLK);
      if (acc) model_accept(re, im, dir);
      else waits++;
      @(negedge CLK);
      if (!acc && waits > 400) begin
        chk("accept_timeout", 64'(waits), 64'd0);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      if (rand_rffd) dft_rffd = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
    end
  endtask

  task automatic core_beat(input logic v, input logic fd, input logic [N-1:0] re, input logic [N-1:0] im,
                           input logic [3:0] be);
    mexp_t e;
    dft_data_valid = v;
    dft_fd_out     = fd;
    dft_xk_re      = re;
    dft_xk_im      = im;
    dft_blk_exp    = be;
    if (v) begin
      if (fd) begin
        if (m_idx > 0) m_err = 1'b1;
        m_idx  = 0;
        m_bexp = be;
      end else if (m_idx < 0) begin
        m_err = 1'b1;
      end else begin
        m_idx++;
      end
      e.re       = re;
      e.im       = im;
      e.is_first = fd;
      e.is_last  = (m_idx == PTS - 1);
      e.bexp     = m_bexp;
      if (e.is_last) begin
        m_frames++;
        m_idx = -1;
      end
      e.fdone = m_frames;
      e.err   = m_err;
      m_q.push_back(e);
    end
    @(negedge CLK);
  endtask

  task automatic core_frame(input logic [3:0] be, input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 2)) core_beat(1'b0, 1'b0, N'($urandom), N'($urandom), 4'($urandom));
      core_beat(1'b1, (i == 0), N'($urandom), N'($urandom), (i == 0) ? be : 4'($urandom));
    end
    dft_data_valid = 1'b0;
    dft_fd_out     = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    SCLR    = 1'b1;
    s_valid = 1'b0;
    model_flush();
    repeat (n) @(negedge CLK);
    SCLR = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((burst_q.size() != 0 || bcnt != 0 || m_q.size() != 0) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    chk("drain_left", 64'(burst_q.size() + m_q.size() + bcnt), 64'd0);
  endtask

  // Core-input monitor: every burst beat must match the next expected buffered sample.
  always @(posedge CLK) begin : mon_burst
    bexp_t e;
    #1;
    if (SCLR) begin
      chk("rst_core_in", {dft_fd_in, dft_xn_re, dft_xn_im}, 64'd0);
      burst_q.delete();
      bcnt = 0;
    end else if (dft_fd_in || bcnt > 0) begin
      if (burst_q.size() == 0) begin
        chk("burst_unexpected", {dft_fd_in, dft_xn_re, dft_xn_im}, 64'd0);
        bcnt = 0;
      end else begin
        e = burst_q.pop_front();
        chk("burst_xn", {dft_xn_re, dft_xn_im}, {e.re, e.im});
        chk("burst_fd_in", dft_fd_in, e.fd);
        chk("burst_dir", dft_fwd_inv, e.dir);
        bcnt = (bcnt == PTS - 1) ? 0 : bcnt + 1;
      end
    end else begin
      chk("idle_core_in", {dft_fd_in, dft_xn_re, dft_xn_im}, 64'd0);
    end
  end

  // Result monitor: pops one expectation per m_valid beat.
  always @(posedge CLK) begin : mon_result
    mexp_t e;
    #1;
    if (SCLR) begin
      chk("rst_result", {m_valid, m_first, m_last, m_blk_exp, frames_done, err, m_re, m_im}, 64'd0);
      m_q.delete();
    end else if (m_valid) begin
      if (m_q.size() == 0) begin
        chk("m_unexpected", m_valid, 64'd0);
      end else begin
        e = m_q.pop_front();
        chk("m_data", {m_re, m_im}, {e.re, e.im});
        chk("m_first", m_first, e.is_first);
        chk("m_last", m_last, e.is_last);
        chk("m_blk_exp", m_blk_exp, e.bexp);
        chk("frames_done", frames_done, e.fdone);
        chk("err", err, e.err);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w, tot, c;
    logic [N-1:0] kr, ki;

    // Reset for two cycles
    @(posedge CLK);
    #1;
    chk("rst_s_ready", s_ready, 64'd0);
    chk("rst_dft_size", dft_size, 64'd4);
    chk("rst_dft_sclr", dft_sclr, 64'd1);
    chk("rst_dft_fwd_inv", dft_fwd_inv, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    SCLR = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 64'd1);
    chk("post_rst_dft_sclr", dft_sclr, 64'd0);
    @(negedge CLK);

    // Continuous fill, core ready
    dft_rffd = 1'b1;
    tot = 0;
    for (int k = 0; k < PTS; k++) begin
      kr = N'(k);
      ki = N'(-k);
      push_sample(kr, ki, 1'b1, w);
      tot += w;
    end
    s_valid = 1'b0;
    chk("fill_stalls", 64'(tot), 64'd0);
    #1;
    chk("s_ready_after_frame", s_ready, 64'd0);
    @(negedge CLK);
    wait_drain(300);

    // Gapped fill, core not ready for a while
    dft_rffd = 1'b0;
    for (int k = 0; k < PTS; k++) begin
      push_sample(N'(1000 + k), N'(2000 + k), (k == 0) ? 1'b0 : 1'b1, w);
      idle(1);
    end
    idle(10);
    dft_rffd = 1'b1;
    @(posedge CLK);
    #1;
    chk("latency_cycle1_fd_in", dft_fd_in, 64'd0);
    @(posedge CLK);
    #1;
    chk("latency_cycle2_fd_in", dft_fd_in, 64'd1);
    @(negedge CLK);
    wait_drain(300);

    // One clean result frame
    core_frame(4'd3, PTS, 1'b0);
    idle(2);
    chk("frames_done_1", frames_done, 64'd1);
    chk("m_blk_exp_held", m_blk_exp, 64'd3);
    chk("err_clean", err, 64'd0);

    // Early restart after 30 beats
    core_frame(4'd5, 30, 1'b0);
    core_frame(4'd6, PTS, 1'b0);
    idle(5);
    chk("err_sticky", err, 64'd1);
    chk("frames_done_2", frames_done, 64'd2);
    apply_reset(2);
    #1;
    chk("err_cleared", err, 64'd0);
    @(negedge CLK);

    // Reset in the middle of a burst
    dft_rffd = 1'b1;
    for (int k = 0; k < PTS; k++) push_sample(N'($urandom), N'($urandom), 1'b1, w);
    s_valid = 1'b0;
    c = 0;
    while (!dft_fd_in && c < 100) begin
      @(negedge CLK);
      c++;
    end
    chk("abort_burst_started", dft_fd_in, 64'd1);
    repeat (20) @(negedge CLK);
    SCLR = 1'b1;
    model_flush();
    @(posedge CLK);
    #1;
    chk("abort_fd_in", dft_fd_in, 64'd0);
    chk("abort_xn", {dft_xn_re, dft_xn_im}, 64'd0);
    @(negedge CLK);
    SCLR = 1'b0;
    #1;
    chk("abort_back_to_fill", s_ready, 64'd1);
    @(negedge CLK);
    for (int k = 0; k < PTS; k++) push_sample(N'(k + 7), N'(3 * k), 1'b0, w);
    s_valid = 1'b0;
    wait_drain(300);

    // Random overlapped traffic on both sides
    rand_rffd = 1'b1;
    fork
      begin
        for (int i = 0; i < 3 * PTS; i++) begin
          push_sample(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), w);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        s_valid   = 1'b0;
        rand_rffd = 1'b0;
        dft_rffd  = 1'b1;
      end
      begin
        for (int f = 0; f < 4; f++) begin
          core_frame(4'($urandom), PTS, 1'b1);
          repeat ($urandom_range(0, 4)) @(negedge CLK);
        end
      end
    join
    wait_drain(600);
    chk("final_frames_done", frames_done, 64'(m_frames));
    chk("final_err", err, 64'(m_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dft_frame_sequencer.md
Name: dft_frame_sequencer

Overview:
- Sits between the sample source and the `dft_0` DFT core, on the same clock.
- Accepts complex samples from an upstream requester over a valid/ready handshake and buffers one full frame of PTS points.
- Streams each frame into the core as a contiguous, gap-free burst, with FD_IN on the first point and a per-frame direction.
- Tags the core's output stream with frame first/last markers and latches the block exponent, the output beat count and a sticky protocol error.

Parameters:
- N, 18, sample and result width per real/imaginary part.
- SIZE_CODE, 4, value driven on the core SIZE input.
- PTS, 60, transform length for SIZE_CODE; it is also the frame buffer depth.

Ports:
- CLK  in  1  system clock.
- SCLR  in  1  synchronous active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sequencer accepts a sample this cycle.
- s_re  in  N  upstream sample, real part.
- s_im  in  N  upstream sample, imaginary part.
- fwd_inv  in  1  transform direction; sampled with the first sample of each frame.
- dft_sclr  out  1  core reset, equal to SCLR (combinational).
- dft_xn_re  out  N  core input, real part.
- dft_xn_im  out  N  core input, imaginary part.
- dft_fd_in  out  1  core first-data strobe.
- dft_fwd_inv  out  1  core direction.
- dft_size  out  6  core size, constant SIZE_CODE.
- dft_rffd  in  1  core ready-for-first-data.
- dft_xk_re  in  N  core result, real part.
- dft_xk_im  in  N  core result, imaginary part.
- dft_blk_exp  in  4  core block exponent.
- dft_fd_out  in  1  core first-output strobe.
- dft_data_valid  in  1  core output valid.
- m_valid  out  1  result beat valid (no backpressure).
- m_re  out  N  result, real part.
- m_im  out  N  result, imaginary part.
- m_first  out  1  first beat of a result frame.
- m_last  out  1  beat PTS-1 of a result frame.
- m_blk_exp  out  4  block exponent of the current result frame.
- frames_done  out  16  count of completed result frames; wraps.
- err  out  1  sticky protocol error.

Behaviour:
- Reset values: all outputs 0, except dft_size = SIZE_CODE and dft_sclr = SCLR. Reset also clears both counters, returns the FSM to FILL and discards any partial frame.
- Frame buffer: PTS x 2N RAM with synchronous read; write address is wr_cnt, read address is rd_cnt.
- FSM states and transitions:
  - FILL: s_ready=1. Each s_valid&s_ready writes the sample at wr_cnt and increments wr_cnt. The first accept captures fwd_inv into frame_dir. When the accept at wr_cnt=PTS-1 completes, wr_cnt clears and the FSM moves to ARM next cycle.
  - ARM: s_ready=0. RAM address 0 is presented. When dft_rffd=1, the FSM moves to BURST.
  - BURST: exactly PTS consecutive cycles.
    - Cycle k drives dft_xn = buf[k].
    - dft_fd_in=1 only on k=0; dft_fwd_inv=frame_dir held for the whole burst.
    - After k=PTS-1: dft_fd_in=0, dft_xn=0, FSM returns to FILL.
- Latency: the first BURST cycle is 2 cycles after entering ARM when dft_rffd is already high.
- Output side runs independently of the FSM, with all outputs registered (1-cycle delay from core outputs):
  - m_valid = dft_data_valid.
  - m_re/m_im = dft_xk_re/dft_xk_im.
  - out_cnt increments per valid beat.
  - m_first=1 when dft_fd_out&dft_data_valid; out_cnt resets to 1 on that beat.
  - m_blk_exp latches dft_blk_exp on the m_first beat and holds it for the frame.
  - m_last=1 on the beat where out_cnt reaches PTS-1 (0-based); frames_done increments on that beat.
- Error conditions, each sets err (cleared only by SCLR):
  - dft_fd_out arrives while out_cnt is nonzero and below PTS (early restart).
  - dft_data_valid without a preceding dft_fd_out since reset or since the last completed frame.
- Boundaries:
  - s_valid held continuously fills a frame in exactly PTS cycles.
  - Upstream stalls never create gaps in BURST.
  - A result frame and a filling input frame may overlap freely.
  - frames_done wraps from 0xFFFF to 0.
  - SCLR mid-BURST aborts the burst and drops dft_fd_in within 1 cycle.

Test Plan:
- Reset: SCLR for 2 cycles -> all outputs 0, dft_size=4, s_ready=1 on the first cycle after SCLR falls.
- Continuous fill: 60 samples re=k, im=-k with s_valid high and dft_rffd=1 -> s_ready falls after 60 accepts, then a 60-cycle BURST with dft_xn_re = 0..59 in order and dft_fd_in high on the first cycle only.
- Gapped fill with dft_rffd held low 10 cycles: s_valid toggles every other cycle, fwd_inv=0 on the first accept then 1 -> burst starts 2 cycles after dft_rffd rises, is contiguous, and dft_fwd_inv=0 throughout.
- Core output model: fd_out plus 60 valid beats with blk_exp=3 -> m_first on beat 0, m_last on beat 59, m_blk_exp=3, frames_done=1.
- Early restart: second dft_fd_out after 30 beats -> err=1 and stays 1 until SCLR.
- Mid-BURST SCLR at k=20 -> dft_fd_in and dft_xn are 0 next cycle, FSM in FILL, and the next frame bursts correctly from sample 0.
